// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC request arbiter: ID width helper and arbiter FSM states.
package cordic_pkg;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int N_REQ_DEFAULT = 4;
   localparam int ID_W          = id_width(N_REQ_DEFAULT);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/cordic_id_fifo.sv
// In-order FIFO of requester IDs for transactions currently inside the core.
module cordic_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [WIDTH-1:0]           head_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_d  = do_push ? wr_q + PW'(1) : wr_q;
      rd_d  = do_pop  ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin sharing of one CORDIC core among N_REQ requesters; results are
// routed back in order using an ID FIFO of accepted grants.
module cordic_req_arbiter
   import cordic_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int XY_W    = 16,
   parameter int ANGLE_W = 32,
   parameter int MAX_OUT = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*XY_W-1:0]        req_x,
   input  logic [N_REQ*XY_W-1:0]        req_y,
   input  logic [N_REQ*ANGLE_W-1:0]     req_z,
   output logic                         core_in_valid,
   input  logic                         core_in_ready,
   output logic [XY_W-1:0]              core_x,
   output logic [XY_W-1:0]              core_y,
   output logic [ANGLE_W-1:0]           core_z,
   input  logic                         core_out_valid,
   output logic                         core_out_ready,
   input  logic [XY_W-1:0]              core_cos,
   input  logic [XY_W-1:0]              core_sin,
   input  logic [XY_W-1:0]              core_mag,
   input  logic [ANGLE_W-1:0]           core_theta,
   output logic [N_REQ-1:0]             rsp_valid,
   input  logic [N_REQ-1:0]             rsp_ready,
   output logic [XY_W-1:0]              rsp_cos,
   output logic [XY_W-1:0]              rsp_sin,
   output logic [XY_W-1:0]              rsp_mag,
   output logic [ANGLE_W-1:0]           rsp_theta,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         err_orphan
);
   localparam int IW = id_width(N_REQ);
   typedef logic [IW-1:0] id_t;

   arb_state_e state_q, state_d;
   id_t        rr_ptr_q, rr_ptr_d, lock_q, lock_d, grant, head;
   logic       err_q, err_d;
   logic       fifo_full, fifo_empty, accept, pop;

   // Scan downward so the nearest valid requester after rr_ptr is the last write.
   always_comb begin
      grant = lock_q;
      if (state_q == IDLE) begin
         grant = rr_ptr_q;
         for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % N_REQ])
               grant = id_t'((int'(rr_ptr_q) + k) % N_REQ);
         end
      end
   end

   // Full is judged on registered occupancy, so a same-cycle pop cannot free a slot.
   assign core_in_valid = rst_n && (|req_valid) && !fifo_full;
   assign accept        = core_in_valid && core_in_ready;

   assign core_x = req_x[int'(grant)*XY_W +: XY_W];
   assign core_y = req_y[int'(grant)*XY_W +: XY_W];
   assign core_z = req_z[int'(grant)*ANGLE_W +: ANGLE_W];

   assign core_out_ready = rst_n && (fifo_empty || rsp_ready[head]);
   assign pop            = core_out_valid && core_out_ready && !fifo_empty;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = accept && (grant == id_t'(i));
         rsp_valid[i] = rst_n && core_out_valid && !fifo_empty && (head == id_t'(i));
      end
   end

   assign rsp_cos    = core_cos;
   assign rsp_sin    = core_sin;
   assign rsp_mag    = core_mag;
   assign rsp_theta  = core_theta;
   assign err_orphan = err_q;

   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      rr_ptr_d = rr_ptr_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (core_in_valid && !core_in_ready) begin
               state_d = LOCKED;
               lock_d  = grant;
            end
         end
         LOCKED: begin
            if (accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) rr_ptr_d = grant;
      if (core_out_valid && fifo_empty) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lock_q   <= '0;
         rr_ptr_q <= id_t'(N_REQ - 1);
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lock_q   <= lock_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   cordic_id_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUT)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (accept),
      .data_i  (grant),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding),
      .head_o  (head)
   );

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Randomized scoreboard bench for cordic_req_arbiter with a behavioural arbiter/core model.
module tb_cordic_req_arbiter;
   localparam int N  = 4;
   localparam int XW = 16;
   localparam int AW = 32;
   localparam int MO = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*XW-1:0] req_x, req_y;
   logic [N*AW-1:0] req_z;
   logic            core_in_valid, core_in_ready, core_out_valid, core_out_ready;
   logic [XW-1:0]   core_x, core_y, core_cos, core_sin, core_mag;
   logic [XW-1:0]   rsp_cos, rsp_sin, rsp_mag;
   logic [AW-1:0]   core_z, core_theta, rsp_theta;
   logic [$clog2(MO+1)-1:0] outstanding;
   logic            err_orphan;

   always #5 clk = ~clk;

   cordic_req_arbiter #(.N_REQ(N), .XY_W(XW), .ANGLE_W(AW), .MAX_OUT(MO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_z(req_z),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
      .core_x(core_x), .core_y(core_y), .core_z(core_z),
      .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
      .core_cos(core_cos), .core_sin(core_sin), .core_mag(core_mag), .core_theta(core_theta),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_mag(rsp_mag), .rsp_theta(rsp_theta),
      .outstanding(outstanding), .err_orphan(err_orphan)
   );

   typedef struct {
      int            id;
      logic [XW-1:0] cos, sin, mag;
      logic [AW-1:0] theta;
   } rsp_t;
   typedef struct {
      logic [XW-1:0] x, y;
      logic [AW-1:0] z;
   } op_t;

   rsp_t exp_q[$];
   op_t  core_q[$];

   logic [XW-1:0] op_x [N];
   logic [XW-1:0] op_y [N];
   logic [AW-1:0] op_z [N];

   int n_chk = 0, n_fail = 0;
   int m_last, m_cnt, m_grant, n_acc;
   bit m_offer, chk_en, out_fire, en_out;
   logic [N-1:0] acc_flag;
   int p_in, p_rsp, p_raise, p_out;

   // Core transfer functions: arbitrary but distinct per field so misrouting shows.
   function automatic logic [XW-1:0] f_cos(input logic [XW-1:0] x);
      return x ^ 16'h5A5A;
   endfunction
   function automatic logic [XW-1:0] f_sin(input logic [XW-1:0] y);
      return y + 16'd3;
   endfunction
   function automatic logic [XW-1:0] f_mag(input logic [XW-1:0] x, input logic [XW-1:0] y);
      return x + y;
   endfunction
   function automatic logic [AW-1:0] f_th(input logic [AW-1:0] z);
      return z ^ 32'hDEADBEEF;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_valid(input int last);
      for (int k = 1; k <= N; k++)
         if (req_valid[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Monitor/scoreboard: observes the handshakes that will complete at the next posedge.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         bit   exp_civ, psh, pp;
         rsp_t r;
         int   h;
         psh = 0; pp = 0;
         acc_flag = '0;
         out_fire = 0;
         chk("outstanding", 64'(outstanding), 64'(m_cnt));
         exp_civ = (|req_valid) && (m_cnt < MO);
         chk("core_in_valid", 64'(core_in_valid), 64'(exp_civ));
         if (exp_civ) begin
            if (!m_offer) begin
               m_offer = 1;
               m_grant = next_valid(m_last);
            end
            chk("core_x", 64'(core_x), 64'(op_x[m_grant]));
            chk("core_z", 64'(core_z), 64'(op_z[m_grant]));
            if (core_in_ready) begin
               chk("req_ready", 64'(req_ready), 64'(1) << m_grant);
               r.id = m_grant;
               r.cos = f_cos(op_x[m_grant]);
               r.sin = f_sin(op_y[m_grant]);
               r.mag = f_mag(op_x[m_grant], op_y[m_grant]);
               r.theta = f_th(op_z[m_grant]);
               exp_q.push_back(r);
               core_q.push_back('{x: core_x, y: core_y, z: core_z});
               acc_flag[m_grant] = 1'b1;
               m_last = m_grant;
               m_offer = 0;
               psh = 1;
               n_acc++;
            end else begin
               chk("req_ready_stall", 64'(req_ready), 64'(0));
            end
         end else begin
            chk("req_ready_idle", 64'(req_ready), 64'(0));
         end
         if (core_out_valid) begin
            if (exp_q.size() == 0) begin
               chk("orphan_ready", 64'(core_out_ready), 64'(1));
               chk("orphan_rsp_valid", 64'(rsp_valid), 64'(0));
               out_fire = 1;
            end else begin
               h = exp_q[0].id;
               chk("rsp_valid", 64'(rsp_valid), 64'(1) << h);
               chk("core_out_ready", 64'(core_out_ready), 64'(rsp_ready[h]));
               if (rsp_ready[h]) begin
                  chk("rsp_cos", 64'(rsp_cos), 64'(exp_q[0].cos));
                  chk("rsp_sin", 64'(rsp_sin), 64'(exp_q[0].sin));
                  chk("rsp_mag", 64'(rsp_mag), 64'(exp_q[0].mag));
                  chk("rsp_theta", 64'(rsp_theta), 64'(exp_q[0].theta));
                  void'(exp_q.pop_front());
                  out_fire = 1;
                  pp = 1;
               end
            end
         end else begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
         end
         m_cnt = m_cnt + int'(psh) - int'(pp);
      end
   end

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (acc_flag[i]) req_valid[i] = 1'b0;
         if (!req_valid[i] && $urandom_range(99) < p_raise) begin
            op_x[i] = XW'($urandom);
            op_y[i] = XW'($urandom);
            op_z[i] = $urandom;
            req_x[i*XW +: XW] = op_x[i];
            req_y[i*XW +: XW] = op_y[i];
            req_z[i*AW +: AW] = op_z[i];
            req_valid[i] = 1'b1;
         end
         rsp_ready[i] = $urandom_range(99) < p_rsp;
      end
      acc_flag = '0;
      core_in_ready = $urandom_range(99) < p_in;
      if (out_fire) begin
         if (core_q.size() > 0) void'(core_q.pop_front());
         core_out_valid = 1'b0;
      end
      out_fire = 0;
      if (!core_out_valid && en_out && core_q.size() > 0 && $urandom_range(99) < p_out) begin
         core_cos = f_cos(core_q[0].x);
         core_sin = f_sin(core_q[0].y);
         core_mag = f_mag(core_q[0].x, core_q[0].y);
         core_theta = f_th(core_q[0].z);
         core_out_valid = 1'b1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic model_reset();
      m_last = N - 1; m_cnt = 0; m_offer = 0;
      exp_q.delete(); core_q.delete();
      acc_flag = '0; out_fire = 0;
   endtask

   initial begin
      int guard;
      model_reset();
      chk_en = 0; en_out = 0; n_acc = 0;
      p_in = 100; p_rsp = 100; p_raise = 0; p_out = 100;
      for (int i = 0; i < N; i++) begin
         op_x[i] = XW'(16'h100 + i); op_y[i] = XW'(16'h200 + i); op_z[i] = 32'h1000 + i;
         req_x[i*XW +: XW] = op_x[i]; req_y[i*XW +: XW] = op_y[i]; req_z[i*AW +: AW] = op_z[i];
      end
      req_valid = '1; rsp_ready = '1; core_in_ready = 1'b1;
      core_out_valid = 1'b1; core_cos = '0; core_sin = '0; core_mag = '0; core_theta = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_in_valid", 64'(core_in_valid), 64'(0));
      chk("rst_core_out_ready", 64'(core_out_ready), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));

      // Release with the FIFO empty and a core result presented: orphan.
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b1;
      chk_en = 1;
      @(negedge clk);
      chk("err_orphan_before", 64'(err_orphan), 64'(0));
      cycle();
      @(negedge clk);
      chk("err_orphan_set", 64'(err_orphan), 64'(1));

      // Fill: all requesters valid, core never returns -> exactly MAX_OUT accepts.
      n_acc = 0; p_raise = 100;
      repeat (20) cycle();
      @(negedge clk);
      chk("full_accepts", 64'(n_acc), 64'(MO));
      chk("full_outstanding", 64'(outstanding), 64'(MO));
      chk("full_no_issue", 64'(core_in_valid), 64'(0));

      en_out = 1;
      repeat (30) cycle();
      p_in = 10; p_rsp = 50; p_raise = 60; p_out = 70;
      repeat (300) cycle();
      p_in = 60; p_rsp = 70; p_raise = 40; p_out = 60;
      repeat (2500) cycle();

      p_raise = 0; p_in = 100; p_rsp = 100; p_out = 100;
      guard = 0;
      while ((exp_q.size() > 0 || (|req_valid)) && guard < 2000) begin
         cycle();
         guard++;
      end
      chk("drain_done", 64'(guard < 2000), 64'(1));
      @(negedge clk);
      chk("drain_outstanding", 64'(outstanding), 64'(0));
      chk("err_orphan_sticky", 64'(err_orphan), 64'(1));

      // Mid-operation reset.
      p_raise = 50; p_rsp = 60; p_in = 70;
      repeat (40) cycle();
      @(posedge clk); #1;
      rst_n = 1'b0; chk_en = 0;
      req_valid = '0; core_out_valid = 1'b0;
      model_reset();
      @(negedge clk);
      chk("midrst_core_in_valid", 64'(core_in_valid), 64'(0));
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_outstanding", 64'(outstanding), 64'(0));
      chk("post_rst_err_orphan", 64'(err_orphan), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
